// File: rtl/fft_fpu_pkg.sv
// ============================================================================
// Module  : fft_fpu_pkg
// Brief   : Shared types and constants for the FFT FP32 add/sub scheduler.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

package fft_fpu_pkg;

    localparam int   FP_W     = 32;
    localparam logic OP_ADD   = 1'b0;
    localparam logic OP_SUB   = 1'b1;
    // Tag id field is sized for the largest supported requester count (8).
    localparam int   TAG_ID_W = 3;

    typedef enum logic [0:0] {
        ARB   = 1'b0,
        PAIR2 = 1'b1
    } sched_state_e;

    typedef struct packed {
        logic                valid;
        logic [TAG_ID_W-1:0] id;
        logic                sub;
    } tag_t;

endpackage

`default_nettype wire

// File: rtl/fpu_add_sub_sched_rr_arbiter.sv
// ============================================================================
// Module  : rr_arbiter
// Brief   : Rotating-priority arbiter; first requester at or after the pointer.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module rr_arbiter #(
    parameter int N_REQ = 4,
    parameter int IDW   = $clog2(N_REQ)
) (
    input  logic [N_REQ-1:0] i_req,
    input  logic [IDW-1:0]   i_ptr,
    output logic [N_REQ-1:0] o_gnt,
    output logic [IDW-1:0]   o_gnt_id,
    output logic             o_gnt_valid
);

    int w_idx;

    always_comb begin
        o_gnt       = '0;
        o_gnt_id    = '0;
        o_gnt_valid = 1'b0;
        w_idx       = 0;
        for (int off = 0; off < N_REQ; off++) begin
            w_idx = (int'(i_ptr) + off) % N_REQ;
            if (!o_gnt_valid && i_req[w_idx]) begin
                o_gnt_valid  = 1'b1;
                o_gnt[w_idx] = 1'b1;
                o_gnt_id     = IDW'(w_idx);
            end
        end
    end

endmodule

`default_nettype wire

// File: rtl/fpu_add_sub_sched.sv
// ============================================================================
// Module  : fpu_add_sub_sched
// Brief   : Round-robin issue of single ops and add/sub butterfly pairs to a
//           shared pipelined FP32 adder, with a tag line to route results.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module fpu_add_sub_sched
    import fft_fpu_pkg::*;
#(
    parameter int N_REQ = 4,
    parameter int LAT   = 3,
    parameter int DW    = FP_W,
    parameter int IDW   = $clog2(N_REQ)
) (
    input  logic                     i_clk,
    input  logic                     i_rst,
    input  logic                     i_flush,
    input  logic [N_REQ-1:0]         i_req_valid,
    input  logic [N_REQ-1:0]         i_req_pair,
    input  logic [N_REQ-1:0]         i_req_add_sub,
    input  logic [N_REQ*DW-1:0]      i_req_a,
    input  logic [N_REQ*DW-1:0]      i_req_b,
    output logic [N_REQ-1:0]         o_req_ready,
    output logic                     o_fpu_valid,
    output logic                     o_fpu_add_sub,
    output logic [DW-1:0]            o_fpu_a,
    output logic [DW-1:0]            o_fpu_b,
    input  logic [DW-1:0]            i_fpu_result,
    output logic                     o_rsp_valid,
    output logic [IDW-1:0]           o_rsp_id,
    output logic                     o_rsp_sub,
    output logic [DW-1:0]            o_rsp_result,
    output logic [$clog2(LAT+1)-1:0] o_inflight
);

    localparam int c_CNT_W = $clog2(LAT+1);

    sched_state_e        r_state;
    logic [IDW-1:0]      r_rr_ptr;
    logic [IDW-1:0]      r_gnt_q;
    tag_t                r_tag [LAT];
    logic [c_CNT_W-1:0]  r_inflight;

    logic [N_REQ-1:0]    w_arb_gnt;
    logic [IDW-1:0]      w_arb_id;
    logic                w_arb_valid;
    logic                w_in_pair2;
    logic [IDW-1:0]      w_sel_id;
    logic                w_sel_pair;
    logic                w_issue;
    logic                w_issue_sub;
    logic                w_done;
    logic [IDW-1:0]      w_next_ptr;
    tag_t                w_tag_in;
    int                  w_cnt;
    logic                w_rsp_id_unused;

    rr_arbiter #(
        .N_REQ (N_REQ),
        .IDW   (IDW)
    ) u_arb (
        .i_req       (i_req_valid),
        .i_ptr       (r_rr_ptr),
        .o_gnt       (w_arb_gnt),
        .o_gnt_id    (w_arb_id),
        .o_gnt_valid (w_arb_valid)
    );

    assign w_in_pair2  = (r_state == PAIR2);
    assign w_sel_id    = w_in_pair2 ? r_gnt_q : w_arb_id;
    assign w_sel_pair  = i_req_pair[w_sel_id];
    // A flush or reset in the issue cycle suppresses the issue entirely.
    assign w_issue     = !i_rst && !i_flush && (w_in_pair2 || w_arb_valid);
    assign w_issue_sub = w_in_pair2 ? OP_SUB
                       : (w_sel_pair ? OP_ADD : i_req_add_sub[w_sel_id]);
    // Pairs are only acknowledged once their second (sub) half issues.
    assign w_done      = w_issue && (w_in_pair2 || !w_sel_pair);
    assign w_next_ptr  = (w_sel_id == IDW'(N_REQ-1)) ? '0 : w_sel_id + IDW'(1);

    always_comb begin
        o_req_ready = '0;
        if (w_done) begin
            o_req_ready[w_sel_id] = 1'b1;
        end
    end

    assign o_fpu_valid   = w_issue;
    assign o_fpu_add_sub = w_issue_sub;
    assign o_fpu_a       = i_req_a[int'(w_sel_id)*DW +: DW];
    assign o_fpu_b       = i_req_b[int'(w_sel_id)*DW +: DW];

    assign w_tag_in.valid = w_issue;
    assign w_tag_in.id    = TAG_ID_W'(w_sel_id);
    assign w_tag_in.sub   = w_issue_sub;

    // Occupancy after the shift: new entry plus all stages except the last.
    always_comb begin
        w_cnt = int'(w_tag_in.valid);
        for (int i = 0; i < LAT-1; i++) begin
            w_cnt = w_cnt + int'(r_tag[i].valid);
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state    <= ARB;
            r_rr_ptr   <= '0;
            r_gnt_q    <= '0;
            r_inflight <= '0;
            for (int i = 0; i < LAT; i++) begin
                r_tag[i] <= '0;
            end
        end else if (i_flush) begin
            r_state    <= ARB;
            r_rr_ptr   <= '0;
            r_gnt_q    <= '0;
            r_inflight <= '0;
            for (int i = 0; i < LAT; i++) begin
                r_tag[i] <= '0;
            end
        end else begin
            r_tag[0]   <= w_tag_in;
            for (int i = 1; i < LAT; i++) begin
                r_tag[i] <= r_tag[i-1];
            end
            r_inflight <= c_CNT_W'(w_cnt);
            case (r_state)
                ARB: begin
                    if (w_issue) begin
                        if (w_sel_pair) begin
                            r_gnt_q <= w_sel_id;
                            r_state <= PAIR2;
                        end else begin
                            r_rr_ptr <= w_next_ptr;
                        end
                    end
                end
                PAIR2: begin
                    r_rr_ptr <= w_next_ptr;
                    r_state  <= ARB;
                end
                default: r_state <= ARB;
            endcase
        end
    end

    assign o_rsp_valid     = r_tag[LAT-1].valid;
    assign o_rsp_id        = r_tag[LAT-1].id[IDW-1:0];
    assign o_rsp_sub       = r_tag[LAT-1].sub;
    assign o_rsp_result    = i_fpu_result;
    assign o_inflight      = r_inflight;
    assign w_rsp_id_unused = ^r_tag[LAT-1].id;

endmodule

`default_nettype wire

// File: tb/tb_fpu_add_sub_sched.sv
// ============================================================================
// Module  : tb_fpu_add_sub_sched
// Brief   : Table-driven bench with a result scoreboard for fpu_add_sub_sched.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_fpu_add_sub_sched;

    localparam int N   = 4;
    localparam int LAT = 3;
    localparam int DW  = 32;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             flush = 1'b0;
    logic [N-1:0]     req_valid = '0;
    logic [N-1:0]     req_pair = '0;
    logic [N-1:0]     req_as = '0;
    logic [N*DW-1:0]  req_a;
    logic [N*DW-1:0]  req_b;
    logic [N-1:0]     req_ready;
    logic             fpu_valid;
    logic             fpu_add_sub;
    logic [DW-1:0]    fpu_a;
    logic [DW-1:0]    fpu_b;
    logic [DW-1:0]    fpu_result;
    logic             rsp_valid;
    logic [1:0]       rsp_id;
    logic             rsp_sub;
    logic [DW-1:0]    rsp_result;
    logic [1:0]       inflight;

    always #5 clk = ~clk;

    fpu_add_sub_sched #(.N_REQ(N), .LAT(LAT), .DW(DW)) dut (
        .i_clk         (clk),
        .i_rst         (rst),
        .i_flush       (flush),
        .i_req_valid   (req_valid),
        .i_req_pair    (req_pair),
        .i_req_add_sub (req_as),
        .i_req_a       (req_a),
        .i_req_b       (req_b),
        .o_req_ready   (req_ready),
        .o_fpu_valid   (fpu_valid),
        .o_fpu_add_sub (fpu_add_sub),
        .o_fpu_a       (fpu_a),
        .o_fpu_b       (fpu_b),
        .i_fpu_result  (fpu_result),
        .o_rsp_valid   (rsp_valid),
        .o_rsp_id      (rsp_id),
        .o_rsp_sub     (rsp_sub),
        .o_rsp_result  (rsp_result),
        .o_inflight    (inflight)
    );

    // Per-requester operands and their exact FP32 sum / difference.
    logic [31:0] a_tab [N];
    logic [31:0] b_tab [N];
    logic [31:0] res_add [N];
    logic [31:0] res_sub [N];

    function automatic logic [31:0] fpu_model(input logic [31:0] a, input logic [31:0] b,
                                              input logic op);
        for (int k = 0; k < N; k++) begin
            if (a == a_tab[k] && b == b_tab[k]) return op ? res_sub[k] : res_add[k];
        end
        return 32'hDEADBEEF;
    endfunction

    logic [31:0] pipe [LAT];
    always @(posedge clk) begin
        pipe[0] <= fpu_valid ? fpu_model(fpu_a, fpu_b, fpu_add_sub) : 32'h0;
        for (int i = 1; i < LAT; i++) pipe[i] <= pipe[i-1];
    end
    assign fpu_result = pipe[LAT-1];

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s @cyc %0d: got %h, expected %h", nm, cyc, act, exp);
        end
    endtask

    typedef struct {
        int         due;
        int         id;
        logic       sub;
        logic [31:0] res;
    } exp_t;

    exp_t sbq[$];
    int   issue_hist[$];

    typedef struct {
        logic       flush;
        logic [3:0] valid;
        logic [3:0] pair;
        logic [3:0] as;
        logic       fv;
        int         id;
        logic       sub;
        logic [3:0] ready;
    } step_t;

    step_t tbl1[$];
    step_t tbl2[$];

    function automatic step_t mk(input logic fl, input logic [3:0] v, input logic [3:0] p,
                                 input logic [3:0] s, input logic fv, input int id,
                                 input logic sub, input logic [3:0] rdy);
        step_t t;
        t.flush = fl; t.valid = v; t.pair = p; t.as = s;
        t.fv = fv; t.id = id; t.sub = sub; t.ready = rdy;
        return t;
    endfunction

    logic [3:0] prev_valid = '0;
    logic [3:0] prev_ready = '0;
    logic       prev_abandon = 1'b1;

    function automatic int inflight_model();
        int n = 0;
        foreach (issue_hist[i]) begin
            if (issue_hist[i] >= cyc - LAT && issue_hist[i] < cyc) n++;
        end
        return n;
    endfunction

    task automatic check_rsp();
        exp_t e;
        if (sbq.size() > 0 && sbq[0].due == cyc) begin
            e = sbq.pop_front();
            chk("rsp_valid", 32'(rsp_valid), 32'd1);
            if (rsp_valid === 1'b1) begin
                chk("rsp_id", 32'(rsp_id), 32'(e.id));
                chk("rsp_sub", 32'(rsp_sub), 32'(e.sub));
                chk("rsp_result", rsp_result, e.res);
            end
        end else begin
            chk("rsp_valid_idle", 32'(rsp_valid), 32'd0);
        end
    endtask

    task automatic apply_step(input step_t s);
        exp_t e;
        @(posedge clk);
        #1;
        for (int k = 0; k < N; k++) begin
            if (prev_valid[k] && !prev_ready[k] && !prev_abandon)
                assert (s.valid[k]) else $error("protocol: requester %0d dropped valid early", k);
        end
        rst       = 1'b0;
        flush     = s.flush;
        req_valid = s.valid;
        req_pair  = s.pair;
        req_as    = s.as;
        @(negedge clk);
        chk("fpu_valid", 32'(fpu_valid), 32'(s.fv));
        chk("req_ready", 32'(req_ready), 32'(s.ready));
        chk("inflight", 32'(inflight), 32'(inflight_model()));
        if (s.fv) begin
            chk("fpu_add_sub", 32'(fpu_add_sub), 32'(s.sub));
            chk("fpu_a", fpu_a, a_tab[s.id]);
            chk("fpu_b", fpu_b, b_tab[s.id]);
        end
        check_rsp();
        if (s.fv) begin
            issue_hist.push_back(cyc);
            e.due = cyc + LAT; e.id = s.id; e.sub = s.sub;
            e.res = s.sub ? res_sub[s.id] : res_add[s.id];
            sbq.push_back(e);
        end
        if (s.flush) begin
            sbq.delete();
            issue_hist.delete();
        end
        prev_valid   = s.valid;
        prev_ready   = s.ready;
        prev_abandon = s.flush;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        a_tab   = '{32'h3F800000, 32'h40400000, 32'h40A00000, 32'h40800000};
        b_tab   = '{32'h40000000, 32'h3F800000, 32'h40000000, 32'h3F000000};
        res_add = '{32'h40400000, 32'h40800000, 32'h40E00000, 32'h40900000};
        res_sub = '{32'hBF800000, 32'h40000000, 32'h40400000, 32'h40600000};
        for (int k = 0; k < N; k++) begin
            req_a[k*DW +: DW] = a_tab[k];
            req_b[k*DW +: DW] = b_tab[k];
        end

        // single op, butterfly, flush, fairness, pair blocking, wrap, flush mid-pair
        tbl1.push_back(mk(0, 4'b0001, 4'b0000, 4'b0000, 1, 0, 0, 4'b0001));
        repeat (3) tbl1.push_back(mk(0, 4'b0000, 4'b0000, 4'b0000, 0, 0, 0, 4'b0000));
        tbl1.push_back(mk(0, 4'b0010, 4'b0010, 4'b0000, 1, 1, 0, 4'b0000));
        tbl1.push_back(mk(0, 4'b0010, 4'b0010, 4'b0000, 1, 1, 1, 4'b0010));
        repeat (3) tbl1.push_back(mk(0, 4'b0000, 4'b0000, 4'b0000, 0, 0, 0, 4'b0000));
        tbl1.push_back(mk(1, 4'b0000, 4'b0000, 4'b0000, 0, 0, 0, 4'b0000));
        tbl1.push_back(mk(0, 4'b1111, 4'b0000, 4'b1010, 1, 0, 0, 4'b0001));
        tbl1.push_back(mk(0, 4'b1111, 4'b0000, 4'b1010, 1, 1, 1, 4'b0010));
        tbl1.push_back(mk(0, 4'b1111, 4'b0000, 4'b1010, 1, 2, 0, 4'b0100));
        tbl1.push_back(mk(0, 4'b1111, 4'b0000, 4'b1010, 1, 3, 1, 4'b1000));
        tbl1.push_back(mk(0, 4'b1111, 4'b0000, 4'b1010, 1, 0, 0, 4'b0001));
        tbl1.push_back(mk(0, 4'b1110, 4'b0000, 4'b1010, 1, 1, 1, 4'b0010));
        tbl1.push_back(mk(0, 4'b1100, 4'b0000, 4'b1010, 1, 2, 0, 4'b0100));
        tbl1.push_back(mk(0, 4'b1000, 4'b0000, 4'b1010, 1, 3, 1, 4'b1000));
        tbl1.push_back(mk(0, 4'b0001, 4'b0000, 4'b0000, 1, 0, 0, 4'b0001));
        tbl1.push_back(mk(0, 4'b0010, 4'b0000, 4'b0000, 1, 1, 0, 4'b0010));
        tbl1.push_back(mk(0, 4'b1100, 4'b0100, 4'b0000, 1, 2, 0, 4'b0000));
        tbl1.push_back(mk(0, 4'b1100, 4'b0100, 4'b0000, 1, 2, 1, 4'b0100));
        tbl1.push_back(mk(0, 4'b1000, 4'b0000, 4'b0000, 1, 3, 0, 4'b1000));
        tbl1.push_back(mk(0, 4'b0100, 4'b0000, 4'b0000, 1, 2, 0, 4'b0100));
        tbl1.push_back(mk(0, 4'b1001, 4'b0000, 4'b0000, 1, 3, 0, 4'b1000));
        tbl1.push_back(mk(0, 4'b0001, 4'b0000, 4'b0000, 1, 0, 0, 4'b0001));
        tbl1.push_back(mk(1, 4'b0010, 4'b0000, 4'b0000, 0, 0, 0, 4'b0000));
        tbl1.push_back(mk(0, 4'b0010, 4'b0000, 4'b0000, 1, 1, 0, 4'b0010));
        tbl1.push_back(mk(0, 4'b0010, 4'b0010, 4'b0000, 1, 1, 0, 4'b0000));
        tbl1.push_back(mk(1, 4'b0010, 4'b0010, 4'b0000, 0, 0, 0, 4'b0000));
        tbl1.push_back(mk(0, 4'b0010, 4'b0010, 4'b0000, 1, 1, 0, 4'b0000));
        tbl1.push_back(mk(0, 4'b0010, 4'b0010, 4'b0000, 1, 1, 1, 4'b0010));
        repeat (4) tbl1.push_back(mk(0, 4'b0000, 4'b0000, 4'b0000, 0, 0, 0, 4'b0000));
        tbl1.push_back(mk(0, 4'b1000, 4'b1000, 4'b0000, 1, 3, 0, 4'b0000));

        // after an async reset mid-pair: pointer back at 0, requester re-presents
        tbl2.push_back(mk(0, 4'b1010, 4'b1000, 4'b0000, 1, 1, 0, 4'b0010));
        tbl2.push_back(mk(0, 4'b1000, 4'b1000, 4'b0000, 1, 3, 0, 4'b0000));
        tbl2.push_back(mk(0, 4'b1000, 4'b1000, 4'b0000, 1, 3, 1, 4'b1000));
        tbl2.push_back(mk(0, 4'b0100, 4'b0000, 4'b0100, 1, 2, 1, 4'b0100));
        repeat (4) tbl2.push_back(mk(0, 4'b0000, 4'b0000, 4'b0000, 0, 0, 0, 4'b0000));

        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("reset_fpu_valid", 32'(fpu_valid), 32'd0);
        chk("reset_req_ready", 32'(req_ready), 32'd0);
        chk("reset_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("reset_inflight", 32'(inflight), 32'd0);

        foreach (tbl1[i]) apply_step(tbl1[i]);

        // state is now PAIR2 for requester 3; pulse reset asynchronously mid-cycle
        @(posedge clk);
        #1;
        rst = 1'b1;
        #1;
        chk("arst_fpu_valid", 32'(fpu_valid), 32'd0);
        chk("arst_req_ready", 32'(req_ready), 32'd0);
        chk("arst_inflight", 32'(inflight), 32'd0);
        chk("arst_rsp_valid", 32'(rsp_valid), 32'd0);
        sbq.delete();
        issue_hist.delete();
        prev_abandon = 1'b1;

        foreach (tbl2[i]) apply_step(tbl2[i]);

        chk("scoreboard_empty", 32'(sbq.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

`default_nettype wire
